bp_uce_mem_arbiter: RTL and testbench

//  Shares one memory command/response channel between num_req_p UCE requesters (port 0 icache UCE,

---
 rtl/bp_uce_mem_arbiter_if.sv | 35 +++
 rtl/bp_uce_mem_arbiter.sv | 110 +++++++++++
 tb/tb_bp_uce_mem_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_uce_mem_arbiter_if.sv
// rtl/bp_uce_mem_arbiter_if.sv - command/response bundle between UCE ports, arbiter and memory
interface bp_uce_mem_arbiter_if #(
  parameter int num_req_p      = 2,
  parameter int lce_id_width_p = 3,
  parameter int msg_width_p    = 16
);
  logic [num_req_p*lce_id_width_p-1:0] lce_id_i;
  logic [num_req_p*msg_width_p-1:0]    mem_cmd_i;
  logic [num_req_p-1:0]                mem_cmd_v_i;
  logic [num_req_p-1:0]                mem_cmd_ready_o;
  logic [msg_width_p-1:0]              mem_cmd_o;
  logic                                mem_cmd_v_o;
  logic                                mem_cmd_ready_i;
  logic [msg_width_p-1:0]              mem_resp_i;
  logic                                mem_resp_v_i;
  logic                                mem_resp_yumi_o;
  logic [msg_width_p-1:0]              mem_resp_o;
  logic [num_req_p-1:0]                mem_resp_v_o;
  logic [num_req_p-1:0]                mem_resp_yumi_i;
  logic                                error_o;

  modport slave (
    input  lce_id_i, mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
    input  mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
    output mem_resp_yumi_o, mem_resp_o, mem_resp_v_o, error_o
  );

  modport master (
    output lce_id_i, mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
    output mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
    input  mem_resp_yumi_o, mem_resp_o, mem_resp_v_o, error_o
  );
endinterface

// File: rtl/bp_uce_mem_arbiter.sv
// rtl/bp_uce_mem_arbiter.sv - round-robin UCE memory command arbiter with lce_id response routing
// The message payload lce_id occupies the low lce_id_width_p bits of each message.
module bp_uce_mem_arbiter #(
  parameter int num_req_p         = 2,
  parameter int max_outstanding_p = 4,
  parameter int lce_id_width_p    = 3,
  parameter int msg_width_p       = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_uce_mem_arbiter_if.slave   bus
);
  localparam int tok_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w = $clog2(max_outstanding_p + 1);

  logic [msg_width_p-1:0] buf_r;
  logic                   buf_v_r;
  logic [tok_w-1:0]       token_r;
  logic [cnt_w-1:0]       count_r [num_req_p];
  logic                   error_r;

  logic                      slot_free;
  logic                      accept;
  logic                      found;
  logic                      misroute;
  logic [num_req_p-1:0]      ready;
  logic [num_req_p-1:0]      inc;
  logic [num_req_p-1:0]      dec;
  logic [num_req_p-1:0]      resp_v;
  logic [msg_width_p-1:0]    cmd_sel;
  logic [lce_id_width_p-1:0] resp_lce;

  assign resp_lce = bus.mem_resp_i[lce_id_width_p-1:0];

  // Ready never looks at any command valid, so UCEs may drive v as a function of ready.
  always_comb begin
    slot_free = ~buf_v_r | bus.mem_cmd_ready_i;
    ready     = '0;
    inc       = '0;
    cmd_sel   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      ready[i] = slot_free && (count_r[i] < cnt_w'(max_outstanding_p)) && (token_r == tok_w'(i));
      if (ready[i]) begin
        cmd_sel = bus.mem_cmd_i[i*msg_width_p +: msg_width_p];
      end
      inc[i] = ready[i] & bus.mem_cmd_v_i[i];
    end
    accept = |inc;
  end

  // Lowest-index owner wins; a response for a port with no credit out is dropped as a misroute.
  always_comb begin
    found    = 1'b0;
    misroute = 1'b0;
    resp_v   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && bus.mem_resp_v_i
          && (resp_lce == bus.lce_id_i[i*lce_id_width_p +: lce_id_width_p])) begin
        found = 1'b1;
        if (count_r[i] != '0) begin
          resp_v[i] = 1'b1;
        end else begin
          misroute = 1'b1;
        end
      end
    end
    if (bus.mem_resp_v_i && !found) begin
      misroute = 1'b1;
    end
    dec = resp_v & bus.mem_resp_yumi_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_r   <= '0;
      buf_v_r <= 1'b0;
      token_r <= '0;
      error_r <= 1'b0;
      for (int i = 0; i < num_req_p; i++) begin
        count_r[i] <= '0;
      end
    end else begin
      if (accept) begin
        buf_r   <= cmd_sel;
        buf_v_r <= 1'b1;
      end else if (bus.mem_cmd_ready_i) begin
        buf_v_r <= 1'b0;
      end
      token_r <= (token_r == tok_w'(num_req_p - 1)) ? '0 : token_r + 1'b1;
      for (int i = 0; i < num_req_p; i++) begin
        if (inc[i] && !dec[i]) begin
          count_r[i] <= count_r[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          count_r[i] <= count_r[i] - 1'b1;
        end
      end
      if (misroute) begin
        error_r <= 1'b1;
      end
    end
  end

  assign bus.mem_cmd_ready_o = ready;
  assign bus.mem_cmd_o       = buf_r;
  assign bus.mem_cmd_v_o     = buf_v_r;
  assign bus.mem_resp_o      = bus.mem_resp_i;
  assign bus.mem_resp_v_o    = resp_v;
  assign bus.mem_resp_yumi_o = (|dec) | misroute;
  assign bus.error_o         = error_r;
endmodule

// File: tb/tb_bp_uce_mem_arbiter.sv
// tb/tb_bp_uce_mem_arbiter.sv - directed and randomized checks of bp_uce_mem_arbiter against a queue model
module tb_bp_uce_mem_arbiter;
  localparam int NREQ = 2;
  localparam int MAX  = 2;
  localparam int LW   = 3;
  localparam int MW   = 16;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bp_uce_mem_arbiter_if #(.num_req_p(NREQ), .lce_id_width_p(LW), .msg_width_p(MW)) bus ();

  bp_uce_mem_arbiter #(
    .num_req_p(NREQ), .max_outstanding_p(MAX), .lce_id_width_p(LW), .msg_width_p(MW)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: grant rotates with the cycle count since reset; the output stage is a FIFO of accepted commands.
  int            cyc;
  int            cnt [NREQ];
  logic [MW-1:0] q [$];
  logic [MW-1:0] m_last;
  bit            m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    q.delete();
    m_last = '0;
    m_err  = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.mem_cmd_i       = '0;
    bus.mem_cmd_v_i     = '0;
    bus.mem_cmd_ready_i = 1'b0;
    bus.mem_resp_i      = '0;
    bus.mem_resp_v_i    = 1'b0;
    bus.mem_resp_yumi_i = '0;
  endtask

  task automatic resp(input bit v, input logic [LW-1:0] id, input logic [NREQ-1:0] yumi);
    bus.mem_resp_v_i    = v;
    bus.mem_resp_i      = {MW'($urandom) >> LW, id};
    bus.mem_resp_yumi_i = yumi;
  endtask

  task automatic cycle(input string tag);
    int             tok;
    int             hit;
    bit             slot, acc, mis, cons;
    logic [NREQ-1:0] er, erv;
    #1;
    tok  = cyc % NREQ;
    slot = (q.size() == 0) || bus.mem_cmd_ready_i;
    er   = '0;
    for (int i = 0; i < NREQ; i++) er[i] = (i == tok) && (cnt[i] < MAX) && slot;
    acc = bus.mem_cmd_v_i[tok] && er[tok];
    hit = -1;
    for (int i = 0; i < NREQ; i++)
      if (hit < 0 && bus.lce_id_i[i*LW +: LW] == bus.mem_resp_i[LW-1:0]) hit = i;
    erv = '0; mis = 1'b0; cons = 1'b0;
    if (bus.mem_resp_v_i) begin
      if (hit < 0 || cnt[hit] == 0) mis = 1'b1;
      else begin
        erv[hit] = 1'b1;
        cons = bus.mem_resp_yumi_i[hit];
      end
    end
    chk({tag, ":ready_o"},   32'(bus.mem_cmd_ready_o), 32'(er));
    chk({tag, ":cmd_v_o"},   32'(bus.mem_cmd_v_o),     32'(q.size() > 0));
    chk({tag, ":cmd_o"},     32'(bus.mem_cmd_o),       32'(m_last));
    chk({tag, ":resp_v_o"},  32'(bus.mem_resp_v_o),    32'(erv));
    chk({tag, ":resp_yumi"}, 32'(bus.mem_resp_yumi_o), 32'(mis | cons));
    chk({tag, ":resp_o"},    32'(bus.mem_resp_o),      32'(bus.mem_resp_i));
    chk({tag, ":error_o"},   32'(bus.error_o),         32'(m_err));
    @(posedge clk);
    if (q.size() > 0 && bus.mem_cmd_ready_i) void'(q.pop_front());
    if (acc) begin
      m_last = bus.mem_cmd_i[tok*MW +: MW];
      q.push_back(m_last);
      cnt[tok]++;
    end
    if (cons) cnt[hit]--;
    if (mis) m_err = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    bus.lce_id_i = {3'd1, 3'd0};
    idle_inputs();
    reset_i = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("t1_rst_cmd_v",  32'(bus.mem_cmd_v_o),     32'd0);
    chk("t1_rst_cmd_o",  32'(bus.mem_cmd_o),       32'd0);
    chk("t1_rst_resp_v", 32'(bus.mem_resp_v_o),    32'd0);
    chk("t1_rst_yumi",   32'(bus.mem_resp_yumi_o), 32'd0);
    chk("t1_rst_err",    32'(bus.error_o),         32'd0);
    reset_i = 1'b0;

    // Fairness: both ports requesting, downstream always ready.
    bus.mem_cmd_v_i     = 2'b11;
    bus.mem_cmd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_cmd_i = {MW'($urandom), MW'($urandom)};
      #1;
      chk("t2_grant", 32'(bus.mem_cmd_ready_o), 32'(1 << (k % 2)));
      cycle("t2");
    end
    chk("t2_cmd_v", 32'(bus.mem_cmd_v_o), 32'd1);

    // Reset mid-traffic: buffer full and port 0 holding two credits.
    reset_i = 1'b1;
    #1;
    chk("t1_mid_cmd_v", 32'(bus.mem_cmd_v_o), 32'd0);
    chk("t1_mid_err",   32'(bus.error_o),     32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    #1;
    chk("t1_first_grant", 32'(bus.mem_cmd_ready_o), 32'b01);
    cycle("t1_after");

    // Credits: port 0 alone until it runs out, then one response frees a slot.
    do_reset();
    bus.mem_cmd_v_i     = 2'b01;
    bus.mem_cmd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_cmd_i = {MW'($urandom), MW'($urandom)};
      cycle("t3");
    end
    #1;
    chk("t3_full", 32'(bus.mem_cmd_ready_o[0]), 32'd0);
    resp(1'b1, 3'd0, 2'b01);
    cycle("t3_resp");
    resp(1'b0, 3'd0, 2'b00);
    cycle("t3_gap");
    #1;
    chk("t3_restore", 32'(bus.mem_cmd_ready_o), 32'b01);
    cycle("t3_accept");

    // Routing: one command from port 1, then its response.
    bus.mem_cmd_v_i = 2'b10;
    cycle("t4_cmd");
    bus.mem_cmd_v_i = 2'b00;
    resp(1'b1, 3'd1, 2'b10);
    #1;
    chk("t4_resp_v", 32'(bus.mem_resp_v_o),    32'b10);
    chk("t4_yumi",   32'(bus.mem_resp_yumi_o), 32'd1);
    cycle("t4");

    // Misroute: unowned id, then a response for port 1 whose credit is already returned.
    resp(1'b1, 3'd7, 2'b00);
    #1;
    chk("t6_resp_v", 32'(bus.mem_resp_v_o),    32'd0);
    chk("t6_yumi",   32'(bus.mem_resp_yumi_o), 32'd1);
    cycle("t6_unowned");
    resp(1'b1, 3'd1, 2'b10);
    cycle("t6_zero_cnt");
    resp(1'b0, 3'd0, 2'b00);
    for (int k = 0; k < 3; k++) cycle("t6_hold");
    chk("t6_sticky", 32'(bus.error_o), 32'd1);
    do_reset();
    chk("t6_cleared", 32'(bus.error_o), 32'd0);

    // Backpressure: fill the buffer, stall five cycles, then drain and refill together.
    bus.mem_cmd_v_i     = 2'b11;
    bus.mem_cmd_ready_i = 1'b0;
    bus.mem_cmd_i       = {MW'($urandom), MW'($urandom)};
    cycle("t5_load");
    for (int k = 0; k < 5; k++) begin
      bus.mem_cmd_i = {MW'($urandom), MW'($urandom)};
      #1;
      chk("t5_stall_ready", 32'(bus.mem_cmd_ready_o), 32'd0);
      cycle("t5_stall");
    end
    bus.mem_cmd_ready_i = 1'b1;
    bus.mem_cmd_i       = {MW'($urandom), MW'($urandom)};
    cycle("t5_release");
    chk("t5_refilled", 32'(bus.mem_cmd_v_o), 32'd1);

    // Random traffic; the first half only returns responses for ports holding credits.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int p;
      bus.mem_cmd_v_i     = NREQ'($urandom);
      bus.mem_cmd_i       = {MW'($urandom), MW'($urandom)};
      bus.mem_cmd_ready_i = ($urandom_range(0, 3) != 0);
      p = $urandom_range(0, 9);
      if (p < 5)      resp($urandom_range(0, 1) == 1, 3'd0, NREQ'($urandom));
      else if (p < 9) resp($urandom_range(0, 1) == 1, 3'd1, NREQ'($urandom));
      else            resp($urandom_range(0, 1) == 1, LW'($urandom), NREQ'($urandom));
      if (k < 200 && (p == 9 || cnt[p < 5 ? 0 : 1] == 0)) bus.mem_resp_v_i = 1'b0;
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
